// File: rtl/stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_pkg
// Shared definitions for the four-digit BCD stopwatch: controller state
// encoding, the largest legal BCD digit value and the number of digits in
// the SS.hh cascade.
// -----------------------------------------------------------------------------
package stopwatch_pkg;

   // Controller states. The encoding is fixed so that debug probes and
   // external logic analysers read the same values as the documentation.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      LAP   = 2'd3
   } state_t;

   localparam logic [3:0] BCD_MAX = 4'd9;
   localparam int         DIGITS  = 4;

endpackage

// File: rtl/stopwatch_bcd_digit.sv
// -----------------------------------------------------------------------------
// bcd_digit
// One decade (0-9) counter stage of the stopwatch cascade.
//
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   synchronous active-high reset, count -> 0
//   enb    in   advance the digit by one this cycle
//   synch  in   synchronous clear, wins over enb
//   roll   out  combinational: digit is at 9 and enabled, so it wraps now
//   count  out  current BCD value, always 0-9
// -----------------------------------------------------------------------------
module bcd_digit
   import stopwatch_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       enb,
   input  logic       synch,
   output logic       roll,
   output logic [3:0] count
);

   // Roll is the carry into the next digit. It must be combinational so the
   // whole cascade advances on the same tick edge.
   assign roll = enb && (count == BCD_MAX);

   // Clear has priority over counting; an enabled 9 wraps to 0.
   always_ff @(posedge clk) begin
      if (reset || synch) begin
         count <= 4'd0;
      end else if (enb) begin
         count <= (count == BCD_MAX) ? 4'd0 : count + 4'd1;
      end
   end

endmodule

// File: rtl/stopwatch_controller.sv
// -----------------------------------------------------------------------------
// stopwatch_controller
// Sequencing controller for a four-digit BCD stopwatch (SS.hh, 00.00-99.99).
// Owns the hundredth-second prescaler, the start/stop/lap/clear state
// machine, the digit carry chain, the lap register and the overflow flag.
//
// Parameters:
//   TICK_DIV   clk cycles per hundredth-second tick (>= 2)
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   startStop  in   debounced single-cycle pulse, toggles running/stopped
//   lap        in   single-cycle pulse, freezes or releases the display
//   clear      in   single-cycle pulse, zeroes the count when stopped
//   running    out  high in RUN and LAP
//   lapHold    out  high in LAP, display shows the captured lap value
//   overflow   out  sticky, set when the count wraps 99.99 -> 00.00
//   display    out  {secTens, secOnes, hunTens, hunOnes} in BCD
// -----------------------------------------------------------------------------
module stopwatch_controller
   import stopwatch_pkg::*;
#(
   parameter int TICK_DIV = 500000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        startStop,
   input  logic        lap,
   input  logic        clear,
   output logic        running,
   output logic        lapHold,
   output logic        overflow,
   output logic [15:0] display
);

   localparam int             PW      = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0]  PRE_MAX = PW'(TICK_DIV - 1);

   state_t                  state;
   logic [PW-1:0]           prescaler;
   logic                    counting;
   logic                    tick;
   logic                    clear_acc;
   logic                    digit_synch;
   logic [4*DIGITS-1:0]     live_count;
   logic [4*DIGITS-1:0]     lap_reg;

   logic                    enb0, enb1, enb2, enb3;
   logic                    roll0, roll1, roll2, roll3;
   logic [3:0]              cnt0, cnt1, cnt2, cnt3;

   // Time only advances in RUN and LAP; LAP freezes the display, not the
   // clock. Clear is honoured only while stopped (IDLE or PAUSE).
   assign counting    = (state == RUN) || (state == LAP);
   assign tick        = counting && (prescaler == PRE_MAX);
   assign clear_acc   = clear && ((state == IDLE) || (state == PAUSE));
   assign digit_synch = reset || clear_acc;

   // Ripple carry chain: a digit advances when the tick reaches it through
   // every lower digit that is rolling over on this same tick.
   assign enb0 = tick;
   assign enb1 = enb0 && roll0;
   assign enb2 = enb1 && roll1;
   assign enb3 = enb2 && roll2;

   bcd_digit u_hun_ones (
      .clk   (clk),
      .reset (reset),
      .enb   (enb0),
      .synch (digit_synch),
      .roll  (roll0),
      .count (cnt0)
   );

   bcd_digit u_hun_tens (
      .clk   (clk),
      .reset (reset),
      .enb   (enb1),
      .synch (digit_synch),
      .roll  (roll1),
      .count (cnt1)
   );

   bcd_digit u_sec_ones (
      .clk   (clk),
      .reset (reset),
      .enb   (enb2),
      .synch (digit_synch),
      .roll  (roll2),
      .count (cnt2)
   );

   bcd_digit u_sec_tens (
      .clk   (clk),
      .reset (reset),
      .enb   (enb3),
      .synch (digit_synch),
      .roll  (roll3),
      .count (cnt3)
   );

   assign live_count = {cnt3, cnt2, cnt1, cnt0};

   // Prescaler: zeroed in IDLE and on an accepted clear, frozen in PAUSE so
   // a resume continues the partially elapsed hundredth without loss or gain.
   always_ff @(posedge clk) begin
      if (reset) begin
         prescaler <= '0;
      end else if ((state == IDLE) || clear_acc) begin
         prescaler <= '0;
      end else if (counting) begin
         prescaler <= tick ? '0 : prescaler + PW'(1);
      end
   end

   // Control state machine with registered running/lapHold, plus the lap
   // register and sticky overflow. Priority is clear > startStop > lap; a
   // lap capture samples the live digits before any same-cycle increment.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         running  <= 1'b0;
         lapHold  <= 1'b0;
         lap_reg  <= '0;
         overflow <= 1'b0;
      end else begin
         if (roll3) begin
            overflow <= 1'b1;
         end
         if (clear_acc) begin
            overflow <= 1'b0;
         end

         unique case (state)
            IDLE: begin
               if (!clear && startStop) begin
                  state   <= RUN;
                  running <= 1'b1;
               end
            end
            RUN: begin
               if (startStop) begin
                  state   <= PAUSE;
                  running <= 1'b0;
               end else if (lap) begin
                  state   <= LAP;
                  lapHold <= 1'b1;
                  lap_reg <= live_count;
               end
            end
            LAP: begin
               if (startStop) begin
                  state   <= PAUSE;
                  running <= 1'b0;
                  lapHold <= 1'b0;
               end else if (lap) begin
                  state   <= RUN;
                  lapHold <= 1'b0;
               end
            end
            PAUSE: begin
               if (clear) begin
                  state <= IDLE;
               end else if (startStop) begin
                  state   <= RUN;
                  running <= 1'b1;
               end
            end
         endcase
      end
   end

   assign display = lapHold ? lap_reg : live_count;

endmodule

// File: tb/tb_stopwatch_controller.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_controller
// Self-checking bench for stopwatch_controller with TICK_DIV = 4. Expected
// output snapshots are queued as each scenario step is driven and popped
// and compared against the DUT outputs on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_stopwatch_controller;

   localparam int TICK_DIV = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        startStop;
   logic        lap;
   logic        clear;
   logic        running;
   logic        lapHold;
   logic        overflow;
   logic [15:0] display;

   typedef struct {
      string       tag;
      logic [15:0] disp;
      logic        run;
      logic        lh;
      logic        ov;
   } exp_t;

   exp_t sb[$];
   int   vectors     = 0;
   int   miscompares = 0;

   stopwatch_controller #(.TICK_DIV(TICK_DIV)) dut (
      .clk       (clk),
      .reset     (reset),
      .startStop (startStop),
      .lap       (lap),
      .clear     (clear),
      .running   (running),
      .lapHold   (lapHold),
      .overflow  (overflow),
      .display   (display)
   );

   // 10 ns clock; the DUT acts on rising edges, the bench on falling edges.
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [15:0] obs,
                              input logic [15:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   // Queue the outputs the DUT should present once the current step settles.
   task automatic expectOutput(input string tag, input logic [15:0] d,
                               input logic r, input logic l, input logic o);
      exp_t e;
      e.tag  = tag;
      e.disp = d;
      e.run  = r;
      e.lh   = l;
      e.ov   = o;
      sb.push_back(e);
   endtask

   // Pop every pending expectation and compare with the DUT outputs now.
   task automatic checkScoreboard();
      exp_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         checkOutput({e.tag, ".display"},  display,           e.disp);
         checkOutput({e.tag, ".running"},  {15'd0, running},  {15'd0, e.run});
         checkOutput({e.tag, ".lapHold"},  {15'd0, lapHold},  {15'd0, e.lh});
         checkOutput({e.tag, ".overflow"}, {15'd0, overflow}, {15'd0, e.ov});
      end
   endtask

   // Drive a one-cycle pulse starting at the current falling edge; returns
   // on the falling edge after the rising edge that sampled it.
   task automatic applyStimulus(input logic ss, input logic lp,
                                input logic cl, input logic rst);
      startStop = ss;
      lap       = lp;
      clear     = cl;
      reset     = rst;
      @(negedge clk);
      startStop = 1'b0;
      lap       = 1'b0;
      clear     = 1'b0;
      reset     = 1'b0;
   endtask

   task automatic idleCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Step: advance, queue expectation, compare.
   task automatic step(input string tag, input int n, input logic [15:0] d,
                       input logic r, input logic l, input logic o);
      idleCycles(n);
      expectOutput(tag, d, r, l, o);
      checkScoreboard();
   endtask

   task automatic pulseStep(input string tag, input logic ss, input logic lp,
                            input logic cl, input logic rst,
                            input logic [15:0] d, input logic r,
                            input logic l, input logic o);
      applyStimulus(ss, lp, cl, rst);
      expectOutput(tag, d, r, l, o);
      checkScoreboard();
   endtask

   initial begin
      reset     = 1'b1;
      startStop = 1'b0;
      lap       = 1'b0;
      clear     = 1'b0;
      idleCycles(2);
      expectOutput("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
      checkScoreboard();
      reset = 1'b0;

      // Start and count ten hundredths (4 cycles each).
      pulseStep("start",     1, 0, 0, 0, 16'h0000, 1, 0, 0);
      step("run40",          40,    16'h0010, 1, 0, 0);
      step("run9999",        39956, 16'h9999, 1, 0, 0);
      step("wrap",           4,     16'h0000, 1, 0, 1);
      step("pre_lap",        100,   16'h0025, 1, 0, 1);

      // Lap freeze for 20 ticks, then release to the live count.
      pulseStep("lap_on",    0, 1, 0, 0, 16'h0025, 1, 1, 1);
      step("lap_hold40",     40,    16'h0025, 1, 1, 1);
      step("lap_hold80",     40,    16'h0025, 1, 1, 1);
      pulseStep("lap_off",   0, 1, 0, 0, 16'h0045, 1, 0, 1);

      // Clear is ignored while running; counting continues.
      pulseStep("clr_run",   0, 0, 1, 0, 16'h0045, 1, 0, 1);
      step("clr_run_cont",   1,     16'h0046, 1, 0, 1);

      // Pause holds everything; resume keeps the prescaler phase.
      pulseStep("pause",     1, 0, 0, 0,16'h0046, 0, 0, 1);
      step("pause100",       100,   16'h0046, 0, 0, 1);
      pulseStep("resume",    1, 0, 0, 0, 16'h0046, 1, 0, 1);
      step("resume2",        2,     16'h0046, 1, 0, 1);
      step("resume3",        1,     16'h0047, 1, 0, 1);

      // Clear while paused, then restart from a zeroed prescaler.
      pulseStep("pause2",    1, 0, 0, 0, 16'h0047, 0, 0, 1);
      pulseStep("clr_pause", 0, 0, 1, 0, 16'h0000, 0, 0, 0);
      pulseStep("restart",   1, 0, 0, 0, 16'h0000, 1, 0, 0);
      step("restart3",       3,     16'h0000, 1, 0, 0);
      step("restart4",       1,     16'h0001, 1, 0, 0);

      // clear + startStop in PAUSE goes to IDLE and stays stopped.
      pulseStep("pause3",    1, 0, 0, 0, 16'h0001, 0, 0, 0);
      pulseStep("clr_ss",    1, 0, 1, 0, 16'h0000, 0, 0, 0);
      step("clr_ss_idle",    8,     16'h0000, 0, 0, 0);
      pulseStep("start2",    1, 0, 0, 0, 16'h0000, 1, 0, 0);
      step("start2_4",       4,     16'h0001, 1, 0, 0);

      // startStop + lap in RUN pauses without entering LAP.
      pulseStep("ss_lap",    1, 1, 0, 0, 16'h0001, 0, 0, 0);
      pulseStep("resume2",   1, 0, 0, 0, 16'h0001, 1, 0, 0);
      step("resume2_10",     10,    16'h0003, 1, 0, 0);

      // Reset mid-RUN.
      pulseStep("rst_run",   0, 0, 0, 1, 16'h0000, 0, 0, 0);
      step("rst_run_idle",   8,     16'h0000, 0, 0, 0);

      // Reset while in LAP.
      pulseStep("start3",    1, 0, 0, 0, 16'h0000, 1, 0, 0);
      step("start3_8",       8,     16'h0002, 1, 0, 0);
      pulseStep("lap2",      0, 1, 0, 0, 16'h0002, 1, 1, 0);
      step("lap2_8",         8,     16'h0002, 1, 1, 0);
      pulseStep("rst_lap",   0, 0, 0, 1, 16'h0000, 0, 0, 0);
      step("rst_lap_idle",   8,     16'h0000, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/stopwatch_controller.md
# stopwatch_controller

Sequencing controller for a four-digit BCD stopwatch (SS.hh, 00.00 to 99.99 s). It owns a prescaler that turns the system clock into a hundredth-second tick. A start/stop/lap/clear state machine drives the enable and synchronous-clear inputs of a cascade of four decade digits. It sits between debounced pushbutton pulses and the seven-segment display driver.

## Interface
- TICK_DIV, default 500000: clk cycles per hundredth-second tick; legal range is 2 or more.
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- startStop  in  1  single-cycle pulse, debounced upstream; toggles running/stopped.
- lap  in  1  single-cycle pulse; freezes the display or releases it.
- clear  in  1  single-cycle pulse; zeroes the count when stopped.
- running  out  1  high in RUN and LAP.
- lapHold  out  1  high in LAP; display shows the captured lap value.
- overflow  out  1  sticky; set when the count wraps from 99.99 to 00.00.
- display  out  16  four BCD digits {secTens, secOnes, hunTens, hunOnes}.

## Operation
- States are IDLE, RUN, PAUSE and LAP.
- Input priority on the same cycle: clear > startStop > lap. Lower-priority pulses in that cycle are dropped.
- IDLE: startStop -> RUN. clear -> stays in IDLE and re-clears the digits, prescaler and overflow. lap is ignored.
- RUN: startStop -> PAUSE. lap -> LAP and loads the lap register with the live count. clear is ignored.
- LAP: lap -> RUN (display released). startStop -> PAUSE (display released; lap value discarded). clear is ignored.
- PAUSE: startStop -> RUN, resuming from the held count and prescaler. clear -> IDLE, with digits, prescaler and overflow zeroed. lap is ignored.
- Prescaler runs from 0 to TICK_DIV-1 only in RUN and LAP. It is held in PAUSE and zeroed in IDLE.
- tick is high for the one cycle in which the prescaler equals TICK_DIV-1 while counting; the prescaler then wraps to 0.
- Digit k enable = tick AND roll of every lower digit.
- roll of a digit = (value == 9) AND its enable. A digit at 9 that is enabled goes to 0.
- When all four digits roll together (99.99 -> 00.00), overflow is set and counting continues.
- display = lapHold ? lap register : live digits. All four digits are always valid BCD (0-9).

## Timing
- Reset values: state IDLE; digits, lap register and prescaler 0; running 0, lapHold 0, overflow 0, display 16'h0000.
- Reset applies at the next edge regardless of state, including mid-count and in LAP.
- All outputs are registered or decoded from registers. A button pulse in cycle n is reflected in running, lapHold and display at cycle n+1.
- Entry from IDLE: the first tick occurs TICK_DIV cycles after the edge that enters RUN. The live count is 00.01 on the following cycle.
- Resuming from PAUSE preserves the prescaler phase; there is no partial-tick loss or gain.
- Lap capture in the same cycle as a tick: capture takes the pre-increment value. The live count still increments.
- The display updates exactly one cycle after each tick edge, and never changes in PAUSE or LAP.
- Clear while in PAUSE: display reads 16'h0000 and overflow reads 0 at n+1.

## Structure
- Package stopwatch_pkg holds:
  - the state encoding constants IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, LAP=2'd3;
  - BCD_MAX=4'd9;
  - DIGITS=4.
- Sub-module bcd_digit (clk, reset, enb, synch, roll, count[3:0]), instantiated four times.
  - Its synch is active-high and clears the digit; it takes priority over enb.
  - The controller drives synch = reset OR clear-accepted.
- The controller top contains the FSM, the prescaler (width $clog2(TICK_DIV)), the carry chain, the lap register and the overflow flag.

## Test plan
All scenarios use TICK_DIV=4.
- Reset, then a startStop pulse, then 40 cycles: display 16'h0010, running 1, overflow 0.
- Run 9999 ticks: display 16'h9999. One more tick: display 16'h0000, overflow 1, running still 1.
- Lap test:
  - At display 16'h0025, pulse lap: lapHold 1 and display holds 0025 for 20 ticks.
  - Pulse lap again: display 16'h0045, lapHold 0.
- Pause and clear:
  - startStop in RUN: running 0 and display stable for 100 cycles.
  - clear while in RUN beforehand: ignored.
  - clear while in PAUSE: display 0, overflow 0, state IDLE. Resume: first increment exactly 4 cycles later.
- Priority and reset:
  - clear together with startStop in PAUSE -> IDLE.
  - startStop together with lap in RUN -> PAUSE, lapHold 0.
  - reset asserted mid-RUN and in LAP -> all outputs at reset values on the next cycle.
